ternary_feed_seq: RTL and testbench
===================================

// Module: ternary_feed_seq
// PURPOSE
//  Initiator/feeder for the ternary matrix-vector multiplier. Accepts a byte stream, packs one
//  step's activations and 2-bit ternary weights, and issues each step to the multiplier for
//  exactly one clock while sequencing its 3-bit row index. Also returns the multiplier's
//  per-row results from the previous frame as a byte stream. Sits between pin I/O and the multiplier.
// PARAMETERS
//  BIT_WIDTH  8   activation/result width; two activations per step
//  IN_LEN     14  ternary weights per step (2 bits each -> 28-bit weight word)
//  OUT_LEN    7   valid result rows returned per frame (row indices 0..OUT_LEN-1)
//  W_BYTES    4   weight bytes per step = ceil(2*IN_LEN/8); derived, not overridden
// PORTS
//  clk           in   1          clock
//  rst           in   1          synchronous reset, active-high
//  in_data       in   8          input byte
//  in_valid      in   1          in_data valid
//  in_ready      out  1          byte accepted when in_valid & in_ready
//  flush         in   1          abort current frame, restart at step 0
//  mult_row      out  3          row/step index to multiplier
//  mult_vec_in   out  2*BIT_WIDTH  {act1, act0} to multiplier
//  mult_w        out  2*IN_LEN   packed ternary weights to multiplier
//  mult_vec_out  in   BIT_WIDTH  multiplier result byte for current mult_row
//  res_data      out  BIT_WIDTH  returned result byte
//  res_idx       out  3          row index of res_data
//  res_valid     out  1          one-cycle strobe, res_data/res_idx valid
//  frame_done    out  1          one-cycle strobe, step 7 issued
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all outputs 0, state GATHER, step=0, byte_cnt=0, have_result=0.
//  - Step = 2+W_BYTES = 6 bytes: b0->act0, b1->act1, b2..b5 -> w little-endian;
//    w = {b5[3:0], b4, b3, b2}; b5[7:4] discarded. Weight code 00=0, 01=+1, 1x=-1 (passed through).
//  - FSM GATHER: in_ready=1; mult_row=step; mult_w=0, mult_vec_in=0 (zero contribution, so
//    multiplier accumulator holds; at step 0 it stays cleared). Each accepted byte goes to
//    shadow regs, byte_cnt++. On acceptance of byte 6: byte_cnt<=0, next state ISSUE.
//  - ISSUE (exactly 1 cycle): in_ready=0; mult_row=step, mult_w/mult_vec_in=shadow values.
//    Next cycle: GATHER, step<=step+1 mod 8, mult_w/mult_vec_in<=0.
//  - Weights non-zero on at most one cycle per step regardless of in_valid gaps (critical:
//    multiplier accumulates every clock while row!=0).
//  - Step 7 ISSUE: frame_done=1 that cycle; have_result<=1; step wraps to 0 so multiplier
//    clears accumulator and latches frame result.
//  - Result return: in ISSUE cycle of step k, if have_result && k<OUT_LEN: res_data<=mult_vec_out,
//    res_idx<=k, res_valid<=1 next cycle (1-cycle latency, strobe 1 cycle). Else res_valid=0.
//    Results are previous frame's; no res_valid during first frame after reset.
//  - res_data sampled as two's complement, no saturation; arithmetic wraps mod 2^BIT_WIDTH in mult.
//  - flush=1 (sync, any state): next cycle GATHER, step=0, byte_cnt=0, mult_w/vec_in=0,
//    partial shadow discarded, no ISSUE/res_valid/frame_done that cycle; have_result kept.
//    flush has priority over byte acceptance and ISSUE; rst has priority over flush.
//  - in_data ignored when in_ready=0; no byte lost/duplicated across ISSUE.
//  - Max throughput: 7 cycles/step, 56 cycles/frame.
// TESTING
//  - Reset: hold rst 2 cycles -> all outputs 0, in_ready=1, mult_row=0; in_valid ignored during rst.
//  - Full frame, back-to-back: 8 steps of {b0=1,b1=2,w=all 01} -> mult_w=0x5555555 for exactly
//    8 single cycles, mult_row 0..7, frame_done once; second frame returns res_data=0x18 idx 0..6.
//  - Negative: 8 steps {act0=5,act1=0,w=all 10} -> next frame res_data=0xD8 (-40) x7, no idx 7.
//  - Backpressure: random in_valid gaps (1-5 cycles) -> same mult_w pulse count/values as
//    back-to-back; mult_w=0 every non-ISSUE cycle; b5[7:4]=0xF ignored.
//  - Flush at byte 3 of step 3 -> mult_row=0, next 6 bytes issue as step 0; prior have_result kept.
//  - rst asserted in ISSUE of step 5 -> next cycle mult_w=0, mult_row=0, no res_valid until a
//    full new frame completes.

Source files
------------

// File: rtl/ternary_feed_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ternary_feed_seq
// Brief    : Packs byte-stream steps into activation/ternary-weight words,
//            issues each step to the multiplier for one clock and streams back
//            the previous frame's per-row results.
// Revision : 1.0
// ============================================================================
module ternary_feed_seq #(
  parameter int BIT_WIDTH = 8,
  parameter int IN_LEN    = 14,
  parameter int OUT_LEN   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [2:0]             mult_row,
  output logic [2*BIT_WIDTH-1:0] mult_vec_in,
  output logic [2*IN_LEN-1:0]    mult_w,
  input  logic [BIT_WIDTH-1:0]   mult_vec_out,
  output logic [BIT_WIDTH-1:0]   res_data,
  output logic [2:0]             res_idx,
  output logic                   res_valid,
  output logic                   frame_done
);

  localparam int W_BYTES      = (2*IN_LEN + 7) / 8;
  localparam int c_step_bytes = 2 + W_BYTES;
  localparam int c_bcw        = $clog2(c_step_bytes);
  localparam logic [c_bcw-1:0] c_last_byte = c_bcw'(c_step_bytes - 1);
  localparam logic [3:0]       c_out_len   = 4'(OUT_LEN);

  typedef enum logic [0:0] {
    ST_GATHER = 1'b0,
    ST_ISSUE  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             step_q, step_d;
  logic [c_bcw-1:0]       byte_cnt_q, byte_cnt_d;
  logic [BIT_WIDTH-1:0]   act0_q, act0_d;
  logic [BIT_WIDTH-1:0]   act1_q, act1_d;
  logic [W_BYTES*8-1:0]   w_buf_q, w_buf_d;
  logic                   have_result_q, have_result_d;
  logic [BIT_WIDTH-1:0]   res_data_q, res_data_d;
  logic [2:0]             res_idx_q, res_idx_d;
  logic                   res_valid_q, res_valid_d;
  logic                   w_issue;
  logic                   w_accept;

  // Weight bits beyond 2*IN_LEN (top nibble of the last weight byte) are dropped.
  generate
    if (W_BYTES*8 > 2*IN_LEN) begin : g_pad
      logic w_pad_unused;
      assign w_pad_unused = ^w_buf_q[W_BYTES*8-1:2*IN_LEN];
    end
  endgenerate

  always_comb begin
    // Flush suppresses the issue pulse so the multiplier never sees a partial step.
    w_issue     = (state_q == ST_ISSUE) && !flush;
    in_ready    = (state_q == ST_GATHER) && !flush;
    w_accept    = in_valid && in_ready;
    mult_row    = step_q;
    mult_w      = w_issue ? w_buf_q[2*IN_LEN-1:0] : '0;
    mult_vec_in = w_issue ? {act1_q, act0_q} : '0;
    frame_done  = w_issue && (step_q == 3'd7);
    res_data    = res_data_q;
    res_idx     = res_idx_q;
    res_valid   = res_valid_q;

    state_d       = state_q;
    step_d        = step_q;
    byte_cnt_d    = byte_cnt_q;
    act0_d        = act0_q;
    act1_d        = act1_q;
    w_buf_d       = w_buf_q;
    have_result_d = have_result_q;
    res_data_d    = res_data_q;
    res_idx_d     = res_idx_q;
    res_valid_d   = 1'b0;

    if (flush) begin
      state_d    = ST_GATHER;
      step_d     = 3'd0;
      byte_cnt_d = '0;
    end else if (state_q == ST_ISSUE) begin
      state_d = ST_GATHER;
      step_d  = step_q + 3'd1;
      if (step_q == 3'd7) begin
        have_result_d = 1'b1;
      end
      if (have_result_q && ({1'b0, step_q} < c_out_len)) begin
        res_data_d  = mult_vec_out;
        res_idx_d   = step_q;
        res_valid_d = 1'b1;
      end
    end else if (w_accept) begin
      if (byte_cnt_q == c_last_byte) begin
        byte_cnt_d = '0;
        state_d    = ST_ISSUE;
      end else begin
        byte_cnt_d = byte_cnt_q + c_bcw'(1);
      end
      if (byte_cnt_q == c_bcw'(0)) act0_d = BIT_WIDTH'(in_data);
      if (byte_cnt_q == c_bcw'(1)) act1_d = BIT_WIDTH'(in_data);
      for (int i = 0; i < W_BYTES; i++) begin
        if (byte_cnt_q == c_bcw'(i + 2)) w_buf_d[i*8 +: 8] = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_GATHER;
      step_q        <= 3'd0;
      byte_cnt_q    <= '0;
      act0_q        <= '0;
      act1_q        <= '0;
      w_buf_q       <= '0;
      have_result_q <= 1'b0;
      res_data_q    <= '0;
      res_idx_q     <= 3'd0;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      byte_cnt_q    <= byte_cnt_d;
      act0_q        <= act0_d;
      act1_q        <= act1_d;
      w_buf_q       <= w_buf_d;
      have_result_q <= have_result_d;
      res_data_q    <= res_data_d;
      res_idx_q     <= res_idx_d;
      res_valid_q   <= res_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ternary_feed_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ternary_feed_seq
// Brief    : Self-checking bench for ternary_feed_seq with a behavioural
//            multiplier and a step/frame level reference model.
// Revision : 1.0
// ============================================================================
module tb_ternary_feed_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [2:0]  mult_row;
  logic [15:0] mult_vec_in;
  logic [27:0] mult_w;
  logic [7:0]  mult_vec_out;
  logic [7:0]  res_data;
  logic [2:0]  res_idx;
  logic        res_valid;
  logic        frame_done;

  always #5 clk = ~clk;

  ternary_feed_seq #(.BIT_WIDTH(8), .IN_LEN(14), .OUT_LEN(7)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .mult_row(mult_row),
    .mult_vec_in(mult_vec_in), .mult_w(mult_w), .mult_vec_out(mult_vec_out),
    .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid),
    .frame_done(frame_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int tcode(input logic [1:0] c);
    return (c == 2'b00) ? 0 : ((c == 2'b01) ? 1 : -1);
  endfunction

  // Row r uses weight 2r against act0 and weight 2r+1 against act1.
  function automatic int contrib(input logic [7:0] a0, input logic [7:0] a1,
                                 input logic [27:0] w, input int r);
    return int'(a0) * tcode(w[4*r +: 2]) + int'(a1) * tcode(w[4*r+2 +: 2]);
  endfunction

  // Behavioural multiplier: sums issued steps over a frame, publishes at frame end.
  int         macc [7];
  logic [7:0] mlat [8];
  assign mult_vec_out = mlat[mult_row];

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 7; r++) macc[r] = 0;
      for (int r = 0; r < 8; r++) mlat[r] <= 8'h00;
    end else if (flush) begin
      for (int r = 0; r < 7; r++) macc[r] = 0;
    end else if (mult_w != 28'd0 || mult_vec_in != 16'd0) begin
      for (int r = 0; r < 7; r++) macc[r] = macc[r] + contrib(mult_vec_in[7:0], mult_vec_in[15:8], mult_w, r);
      if (frame_done) begin
        for (int r = 0; r < 7; r++) begin
          mlat[r] <= 8'(macc[r]);
          macc[r] = 0;
        end
      end
    end
  end

  typedef struct {
    logic [2:0]  row;
    logic [27:0] w;
    logic [15:0] vec;
  } pulse_t;

  pulse_t      exp_p[$];
  logic [10:0] exp_r[$];
  logic [7:0]  part[$];
  int          ref_step;
  bit          ref_have;
  int          ref_cur [7];
  int          ref_prev[7];
  int          ref_frames = 0;
  int          pushed = 0;

  task automatic ref_reset();
    ref_step = 0;
    ref_have = 1'b0;
    ref_cur  = '{default: 0};
    ref_prev = '{default: 0};
    part.delete();
    exp_r.delete();
  endtask

  task automatic finish_step();
    logic [7:0]  a0, a1;
    logic [27:0] w;
    a0 = part[0];
    a1 = part[1];
    w  = {part[5][3:0], part[4], part[3], part[2]};
    exp_p.push_back('{3'(ref_step), w, {a1, a0}});
    pushed++;
    if (ref_have && ref_step < 7) exp_r.push_back({3'(ref_step), 8'(ref_prev[ref_step])});
    for (int r = 0; r < 7; r++) ref_cur[r] += contrib(a0, a1, w, r);
    if (ref_step == 7) begin
      ref_prev = ref_cur;
      ref_cur  = '{default: 0};
      ref_have = 1'b1;
      ref_frames++;
    end
    ref_step = (ref_step + 1) % 8;
    part.delete();
  endtask

  bit     mon_en = 1'b0;
  int     pulses = 0;
  int     fdone_cnt = 0;
  pulse_t e;
  logic [10:0] er;

  always @(negedge clk) begin
    if (mon_en) begin
      if (mult_w != 28'd0 || mult_vec_in != 16'd0) begin
        pulses++;
        if (exp_p.size() == 0) begin
          check("extra_pulse_w", 64'(mult_w), 64'd0);
        end else begin
          e = exp_p.pop_front();
          check("mult_row", 64'(mult_row), 64'(e.row));
          check("mult_w", 64'(mult_w), 64'(e.w));
          check("mult_vec_in", 64'(mult_vec_in), 64'(e.vec));
          check("frame_done", 64'(frame_done), 64'(e.row == 3'd7));
        end
      end else if (frame_done) begin
        check("frame_done_idle", 64'(frame_done), 64'd0);
      end
      if (frame_done) fdone_cnt++;
      if (res_valid) begin
        if (exp_r.size() == 0) begin
          check("extra_res_valid", 64'(res_valid), 64'd0);
        end else begin
          er = exp_r.pop_front();
          check("res_idx", 64'(res_idx), 64'(er[10:8]));
          check("res_data", 64'(res_data), 64'(er[7:0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (!acc) begin
      check("handshake_timeout", 64'd0, 64'd1);
    end else begin
      part.push_back(b);
      if (part.size() == 6) finish_step();
    end
  endtask

  task automatic send_step(input logic [7:0] a0, input logic [7:0] a1,
                           input logic [27:0] w, input logic [3:0] hi, input bit gaps);
    logic [7:0] bytes [6];
    bytes = '{a0, a1, w[7:0], w[15:8], w[23:16], {hi, w[27:24]}};
    for (int i = 0; i < 6; i++) send_byte(bytes[i], gaps ? int'($urandom_range(1, 5)) : 0);
  endtask

  task automatic send_random_step(input bit gaps);
    send_step(8'($urandom) | 8'h01, 8'($urandom), 28'($urandom), 4'hF, gaps);
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    ref_reset();
    tick();
    tick();
    check("rst_mult_w", 64'(mult_w), 64'd0);
    check("rst_mult_vec_in", 64'(mult_vec_in), 64'd0);
    check("rst_mult_row", 64'(mult_row), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_idx", 64'(res_idx), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst      = 1'b0;
    in_valid = 1'b0;
    mon_en   = 1'b1;

    // Back-to-back frames of +1 weights, then -1 weights.
    repeat (2) for (int s = 0; s < 8; s++) send_step(8'd1, 8'd2, 28'h5555555, 4'h0, 1'b0);
    repeat (2) for (int s = 0; s < 8; s++) send_step(8'd5, 8'd0, 28'hAAAAAAA, 4'h0, 1'b0);
    repeat (3) tick();

    // Random data with input gaps.
    repeat (2) for (int s = 0; s < 8; s++) send_random_step(1'b1);
    repeat (3) tick();

    // Flush three bytes into step 3.
    for (int s = 0; s < 3; s++) send_random_step(1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_mult_row", 64'(mult_row), 64'd0);
    check("flush_mult_w", 64'(mult_w), 64'd0);
    part.delete();
    ref_step = 0;
    ref_cur  = '{default: 0};
    repeat (2) for (int s = 0; s < 8; s++) send_random_step(1'b0);
    repeat (3) tick();

    // Reset while step 5 is being issued.
    for (int s = 0; s < 6; s++) send_random_step(1'b0);
    rst = 1'b1;
    tick();
    check("rst_issue_mult_w", 64'(mult_w), 64'd0);
    check("rst_issue_mult_row", 64'(mult_row), 64'd0);
    check("rst_issue_res_valid", 64'(res_valid), 64'd0);
    rst = 1'b0;
    ref_reset();
    repeat (2) for (int s = 0; s < 8; s++) send_random_step(1'b1);
    repeat (5) tick();

    check("pulses_pending", 64'(exp_p.size()), 64'd0);
    check("results_pending", 64'(exp_r.size()), 64'd0);
    check("pulse_count", 64'(pulses), 64'(pushed));
    check("frame_done_count", 64'(fdone_cnt), 64'(ref_frames));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
